// File: rtl/rv32i_run_monitor.sv
// Run monitor for the rv32i retire trace: run-state FSM, retire/memory-write
// counters, register-write signature and a circular trace of the last DEPTH retires.
module rv32i_run_monitor #(
  parameter  int XLEN       = 32,
  parameter  int DEPTH      = 16,
  parameter  int MAX_CYCLES = 1024,
  localparam int CW         = $clog2(MAX_CYCLES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     en_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic                     reg_wrt_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     illegal_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [2:0]               state_o,
  output logic                     done_o,
  output logic [CW-1:0]            cycle_cnt_o,
  output logic [CW-1:0]            mem_wr_cnt_o,
  output logic [XLEN-1:0]          sig_o,
  output logic [XLEN-1:0]          end_pc_o,
  output logic [XLEN-1:0]          trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic                     trace_valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    HALTED  = 3'd2,
    TIMEOUT = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cycle_cnt;
  logic [CW-1:0]   mem_wr_cnt;
  logic [XLEN-1:0] sig;
  logic [XLEN-1:0] end_pc;
  logic [PW-1:0]   wr_ptr;
  logic [FW-1:0]   fill_cnt;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            retire;
  logic [CW-1:0]   cnt_next;
  logic            is_fault;
  logic            is_halt;
  logic [PW-1:0]   rd_ptr;

  assign retire   = (state == RUN) && en_i;
  assign cnt_next = cycle_cnt + 1'b1;
  assign is_fault = illegal_i || (pc_i[1:0] != 2'b00);
  assign is_halt  = (instr_i == 32'h0000_006F) || (instr_i == 32'h0000_0073);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      state      <= IDLE;
      cycle_cnt  <= '0;
      mem_wr_cnt <= '0;
      sig        <= '0;
      end_pc     <= '0;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= RUN;
            cycle_cnt  <= '0;
            mem_wr_cnt <= '0;
            sig        <= '0;
            end_pc     <= '0;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
          end
        end
        RUN: begin
          if (en_i) begin
            wr_ptr    <= wr_ptr + 1'b1;
            cycle_cnt <= cnt_next;
            if (fill_cnt != FW'(DEPTH)) fill_cnt <= fill_cnt + 1'b1;
            if (mem_wrt_i) mem_wr_cnt <= mem_wr_cnt + 1'b1;
            if (reg_wrt_i && (reg_addr_i != 5'd0))
              sig <= {sig[XLEN-2:0], sig[XLEN-1]} ^ reg_data_i ^ XLEN'(reg_addr_i);
            // Termination priority: fault, then halt, then watchdog.
            if (is_fault) begin
              state  <= FAULT;
              end_pc <= pc_i;
            end else if (is_halt) begin
              state  <= HALTED;
              end_pc <= pc_i;
            end else if (cnt_next == CW'(MAX_CYCLES)) begin
              state  <= TIMEOUT;
              end_pc <= pc_i;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // NOTE: the trace arrays carry no reset; stale contents are hidden by
  // gating the read port with trace_valid_o, which keeps them plain RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i && retire) begin
      pc_mem[wr_ptr]    <= pc_i;
      instr_mem[wr_ptr] <= instr_i;
    end
  end

  // Index 0 is the most recent entry; PW-bit arithmetic wraps modulo DEPTH.
  assign rd_ptr        = wr_ptr - PW'(1) - rd_idx_i;
  assign trace_valid_o = FW'(rd_idx_i) < fill_cnt;
  assign trace_pc_o    = trace_valid_o ? pc_mem[rd_ptr]    : '0;
  assign trace_instr_o = trace_valid_o ? instr_mem[rd_ptr] : '0;

  assign state_o      = state;
  assign done_o       = (state == HALTED) || (state == TIMEOUT) || (state == FAULT);
  assign cycle_cnt_o  = cycle_cnt;
  assign mem_wr_cnt_o = mem_wr_cnt;
  assign sig_o        = sig;
  assign end_pc_o     = end_pc;

endmodule

// File: doc/rv32i_run_monitor.md
Name: rv32i_run_monitor

Overview:
Parametrised, synthesizable run monitor that sits beside rv32i_top and observes its per-cycle retire trace (pc, instr, register write, memory write, illegal-opcode flag). Tracks run state (idle/run/halted/timeout/fault) and counts retired instructions and memory writes. Keeps a circular trace buffer of the last DEPTH retired {pc, instr} pairs and a rolling signature of register writes. Benches and on-board debug check a run from a few status outputs instead of probing hierarchical register-file and memory paths.

Parameters:
XLEN, 32, data/address width of all trace inputs and trace-buffer words
DEPTH, 16, trace buffer entries; power of two, >= 2
MAX_CYCLES, 1024, watchdog limit on retired instructions before TIMEOUT; >= 1
CW, $clog2(MAX_CYCLES+1), width of the counters (derived, not overridden)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
start_i  in  1  pulse: IDLE->RUN
en_i  in  1  retire qualifier; 1 = the CPU retired one instruction this cycle
pc_i  in  XLEN  pc of the retiring instruction
instr_i  in  32  retiring instruction word
reg_wrt_i  in  1  register-file write this cycle
reg_addr_i  in  5  destination register
reg_data_i  in  XLEN  write-back data
mem_wrt_i  in  1  data-memory write this cycle
illegal_i  in  1  unrecognised-opcode flag from the decoder
rd_idx_i  in  $clog2(DEPTH)  trace read index, 0 = most recent
state_o  out  3  0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT, 4 FAULT
done_o  out  1  state in {HALTED, TIMEOUT, FAULT}
cycle_cnt_o  out  CW  retired-instruction count
mem_wr_cnt_o  out  CW  memory writes counted
sig_o  out  XLEN  register-write signature
end_pc_o  out  XLEN  pc of the instruction that ended the run
trace_pc_o  out  XLEN  buffered pc at rd_idx_i
trace_instr_o  out  32  buffered instr at rd_idx_i
trace_valid_o  out  1  rd_idx_i < fill count

Behaviour:
- Reset, synchronous: state IDLE; all counters, sig_o, end_pc_o, write pointer and fill count 0. Trace outputs read 0 after reset (buffer cleared, or gated by trace_valid_o). Reset wins over every other event, including mid-RUN.
- IDLE: ignores en_i. start_i=1 moves to RUN on the next edge and clears counters, sig, end_pc, pointer and fill count.
- start_i outside IDLE is ignored. Terminal states hold until reset.
- RUN, en_i=0: nothing changes (pause).
- RUN, en_i=1 (one retire): in the same edge
  - write {pc_i, instr_i} to the buffer at the write pointer; the pointer wraps modulo DEPTH; fill count saturates at DEPTH
  - cycle_cnt +1
  - mem_wr_cnt +1 if mem_wrt_i
  - if reg_wrt_i and reg_addr_i != 0: sig <= {sig[XLEN-2:0], sig[XLEN-1]} ^ reg_data_i ^ zero-extended reg_addr_i. Writes to x0 are ignored.
- Termination, evaluated on the same retire, priority FAULT > HALTED > TIMEOUT:
  - FAULT: illegal_i=1 or pc_i[1:0] != 0
  - HALTED: instr_i == 32'h0000006F (jal x0,0 self-loop) or 32'h00000073 (ecall)
  - TIMEOUT: the incremented cycle_cnt == MAX_CYCLES
  - On any termination end_pc_o <= pc_i. The terminating instruction is still traced and counted.
- Counters never exceed MAX_CYCLES, because TIMEOUT stops counting.
- Trace read is combinational: entry = (wr_ptr - 1 - rd_idx_i) mod DEPTH.
- Latency: status outputs are registered and reflect a retire one edge later; trace outputs follow rd_idx_i with zero cycles of latency.

Test Plan:
- Reset, start, 4 retires with pc 0,4,8,C (instr=NOP 0x00000013), then pc 0x10 with instr 0x0000006F -> state 2, cycle_cnt 5, end_pc 0x10, rd_idx 0 gives pc 0x10, rd_idx 4 gives pc 0.
- Register writes x1=5 then x2=7 -> sig 0x4 after the first, 0xD after the second. A write to x0=0xFFFF_FFFF leaves sig 0xD.
- illegal_i=1 and instr=0x0000006F on the same retire -> FAULT (4), end_pc = that pc. Separately, pc_i=0x6 -> FAULT.
- MAX_CYCLES=8, 8 NOP retires -> TIMEOUT on the 8th, cycle_cnt 8. Further en_i has no effect and start_i is ignored.
- DEPTH=4, 6 retires with pc 0..0x14 -> rd_idx 0..3 give 0x14,0x10,0xC,0x8, all with trace_valid_o=1. After only 2 retires, rd_idx 2 gives trace_valid_o=0.
- rst_i asserted mid-RUN after 3 retires plus en_i gaps and 2 mem writes -> next cycle IDLE, all counters 0. Then start_i with no retires -> cycle_cnt stays 0 while en_i=0.
